// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder and the
// core's load/store alignment logic.
package dmem_pkg;

    // Access size encodings as carried on the size port (funct3[1:0]).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Responder states. The ST_ prefix keeps the wait state from colliding
    // with the WAIT parameter of the responder.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Access fault: illegal size code, or a half/word that is not naturally aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = lo[0];
            SZ_WORD: fault = (lo != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for loads and stores: builds the write byte mask,
// replicates store data onto every lane, and extracts/extends load data.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        u_en,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed lane(s) of the word and build mask/replicated data.
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        ldata   = 32'h0;
        case (addr_lo)
            2'd0:    ld_byte = rword[7:0];
            2'd1:    ld_byte = rword[15:8];
            2'd2:    ld_byte = rword[23:16];
            default: ld_byte = rword[31:24];
        endcase
        ld_half = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
                ldata   = u_en ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                ldata   = u_en ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            SZ_WORD: begin
                byte_en = 4'b1111;
                wword   = wdata;
                ldata   = rword;
            end
            default: begin
                byte_en = 4'b0000;
                ldata   = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts CPU load/store requests over req/ack,
// inserts WAIT wait states, performs lane-masked writes and returns
// extended load data with a fault flag for misaligned/illegal accesses.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic              u_en,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              enter_resp;

    logic              cap_we, cap_u_en;
    logic [1:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;

    logic              sel_we, sel_u_en;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    logic              fault;
    logic              mem_we;
    logic [31:0]       rword;
    logic [3:0]        byte_en;
    logic [31:0]       wword;
    logic [31:0]       ldata;

    logic [31:0]       mem [DEPTH];

    // With WAIT=0 the response is formed on the acceptance edge itself, so
    // the live request fields are used while idle and the captured copy otherwise.
    assign sel_we    = (state == ST_IDLE) ? we    : cap_we;
    assign sel_u_en  = (state == ST_IDLE) ? u_en  : cap_u_en;
    assign sel_size  = (state == ST_IDLE) ? size  : cap_size;
    assign sel_addr  = (state == ST_IDLE) ? addr  : cap_addr;
    assign sel_wdata = (state == ST_IDLE) ? wdata : cap_wdata;

    assign fault  = misaligned(sel_size, sel_addr[1:0]);
    assign rword  = mem[sel_addr[ADDR_W-1:2]];
    assign mem_we = enter_resp && sel_we && !fault && reset_n;

    dmem_lane u_lane (
        .size    (sel_size),
        .addr_lo (sel_addr[1:0]),
        .u_en    (sel_u_en),
        .wdata   (sel_wdata),
        .rword   (rword),
        .byte_en (byte_en),
        .wword   (wword),
        .ldata   (ldata)
    );

    // Next-state logic for the IDLE -> WAIT -> RESP sequence and wait counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter, request capture and registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            cap_we    <= 1'b0;
            cap_u_en  <= 1'b0;
            cap_size  <= SZ_BYTE;
            cap_addr  <= '0;
            cap_wdata <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack   <= enter_resp;
            err   <= enter_resp && fault;
            if (state == ST_IDLE && req) begin
                cap_we    <= we;
                cap_u_en  <= u_en;
                cap_size  <= size;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end
            if (enter_resp) begin
                rdata <= (fault || sel_we) ? 32'h0 : ldata;
            end
        end
    end

    // Storage is deliberately not reset; stores commit lane by lane on RESP entry.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[sel_addr[ADDR_W-1:2]][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Testbench for dmem_resp: two instances (WAIT=2 and WAIT=0) checked against
// a byte-addressed reference memory model with directed and random accesses.
module tb_dmem_resp;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req [2];
    logic              we, u_en;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack   [2];
    logic [31:0]       rdata [2];
    logic              err   [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit pending  = 0;

    logic [7:0] model_mem [2][2**ADDR_W];

    dmem_resp #(.ADDR_W(ADDR_W), .WAIT(2)) dut_w2 (
        .clk(clk), .reset_n(reset_n), .req(req[0]), .we(we), .u_en(u_en),
        .size(size), .addr(addr), .wdata(wdata),
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0])
    );

    dmem_resp #(.ADDR_W(ADDR_W), .WAIT(0)) dut_w0 (
        .clk(clk), .reset_n(reset_n), .req(req[1]), .we(we), .u_en(u_en),
        .size(size), .addr(addr), .wdata(wdata),
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: byte-addressed little-endian memory.
    task automatic model_access(input int inst, input logic w, input logic u,
                                input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] exp_r, output logic exp_e);
        int nbytes;
        logic [31:0] v;
        logic [ADDR_W-1:0] idx;
        exp_e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        exp_r = 32'h0;
        if (exp_e) return;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 32'h0;
        for (int k = 0; k < nbytes; k++) begin
            idx = ADDR_W'(a + k);
            if (w) model_mem[inst][idx] = wd[8*k +: 8];
            else   v[8*k +: 8] = model_mem[inst][idx];
        end
        if (w) return;
        if (nbytes == 1)      exp_r = u ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (nbytes == 2) exp_r = u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else                  exp_r = v;
    endtask

    // One complete transaction on instance inst; hold keeps req high so the
    // next call presents a back-to-back request during the response cycle.
    task automatic apply_stimulus(input int inst, input logic w, input logic u,
                                  input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                                  input logic [31:0] wd, input bit hold,
                                  output logic [31:0] got_r, output logic got_e);
        int lat, exp_lat;
        logic [31:0] exp_r;
        logic exp_e;
        if (!pending) @(negedge clk);
        exp_lat = ((inst == 0) ? 2 : 0) + 1 + (pending ? 1 : 0);
        we = w; u_en = u; size = sz; addr = a; wdata = wd;
        req[inst] = 1'b1;
        model_access(inst, w, u, sz, a, wd, exp_r, exp_e);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack[inst] && lat < 40);
        got_r = rdata[inst];
        got_e = err[inst];
        check_output("latency", 32'(lat), 32'(exp_lat));
        check_output("err", {31'h0, got_e}, {31'h0, exp_e});
        check_output("rdata", got_r, exp_r);
        if (hold) begin
            pending = 1;
        end else begin
            pending = 0;
            req[inst] = 1'b0;
            @(posedge clk); #1;
            check_output("ack_pulse", {31'h0, ack[inst]}, 32'h0);
        end
    endtask

    logic [31:0] r;
    logic        e;
    logic [31:0] keep_word;
    logic [31:0] exp_dummy;
    logic        exp_e_dummy;

    initial begin
        reset_n = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0;
        we = 1'b0; u_en = 1'b0; size = 2'd0; addr = '0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("rst_ack", {31'h0, ack[i]}, 32'h0);
            check_output("rst_err", {31'h0, err[i]}, 32'h0);
            check_output("rst_rdata", rdata[i], 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Fill bytes 0..255 of both memories so every later read is defined.
        for (int i = 0; i < 2; i++)
            for (int wi = 0; wi < 64; wi++)
                apply_stimulus(i, 1'b1, 1'b0, 2'd2, ADDR_W'(wi * 4), $urandom, 1'b0, r, e);

        // Word store/load at 0x10.
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 14'h0010, 32'hDEADBEEF, 1'b0, r, e);
        apply_stimulus(0, 1'b0, 1'b0, 2'd2, 14'h0010, 32'h0, 1'b0, r, e);
        check_output("word_ld", r, 32'hDEADBEEF);

        // Byte lane merge and sign/zero extension.
        apply_stimulus(0, 1'b1, 1'b0, 2'd2, 14'h0010, 32'h11223344, 1'b0, r, e);
        apply_stimulus(0, 1'b1, 1'b0, 2'd0, 14'h0013, 32'h000000A5, 1'b0, r, e);
        apply_stimulus(0, 1'b0, 1'b0, 2'd0, 14'h0013, 32'h0, 1'b0, r, e);
        check_output("byte_ld_s", r, 32'hFFFFFFA5);
        apply_stimulus(0, 1'b0, 1'b1, 2'd0, 14'h0013, 32'h0, 1'b0, r, e);
        check_output("byte_ld_u", r, 32'h000000A5);
        apply_stimulus(0, 1'b0, 1'b0, 2'd2, 14'h0010, 32'h0, 1'b0, r, e);
        check_output("merged_word", r, 32'hA5223344);

        // Half store/load and a misaligned half store that must not write.
        apply_stimulus(0, 1'b1, 1'b0, 2'd1, 14'h0022, 32'h00008001, 1'b0, r, e);
        apply_stimulus(0, 1'b0, 1'b0, 2'd1, 14'h0022, 32'h0, 1'b0, r, e);
        check_output("half_ld_s", r, 32'hFFFF8001);
        apply_stimulus(0, 1'b1, 1'b0, 2'd1, 14'h0021, 32'h0000FFFF, 1'b0, r, e);
        check_output("mis_half_err", {31'h0, e}, 32'h1);
        check_output("mis_half_rdata", r, 32'h0);
        apply_stimulus(0, 1'b0, 1'b0, 2'd2, 14'h0020, 32'h0, 1'b0, r, e);
        keep_word = r;
        check_output("half_upper", {16'h0, keep_word[31:16]}, 32'h00008001);

        // Illegal size and misaligned word load.
        apply_stimulus(0, 1'b0, 1'b0, 2'd3, 14'h0010, 32'h0, 1'b0, r, e);
        check_output("sz11_err", {31'h0, e}, 32'h1);
        apply_stimulus(0, 1'b0, 1'b0, 2'd2, 14'h0006, 32'h0, 1'b0, r, e);
        check_output("mis_word_err", {31'h0, e}, 32'h1);
        check_output("mis_word_rdata", r, 32'h0);

        // Back-to-back loads with req held high on the zero-wait instance.
        apply_stimulus(1, 1'b0, 1'b0, 2'd2, 14'h0040, 32'h0, 1'b1, r, e);
        apply_stimulus(1, 1'b0, 1'b1, 2'd1, 14'h0046, 32'h0, 1'b1, r, e);
        apply_stimulus(1, 1'b0, 1'b0, 2'd0, 14'h0049, 32'h0, 1'b0, r, e);

        // Store aborted by reset while waiting: no ack and no write.
        @(negedge clk);
        we = 1'b1; u_en = 1'b0; size = 2'd2; addr = 14'h0030; wdata = ~32'h0;
        req[0] = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_output("abort_ack", {31'h0, ack[0]}, 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_output("abort_noack", {31'h0, ack[0]}, 32'h0);
        end
        model_access(0, 1'b0, 1'b0, 2'd2, 14'h0030, 32'h0, exp_dummy, exp_e_dummy);
        apply_stimulus(0, 1'b0, 1'b0, 2'd2, 14'h0030, 32'h0, 1'b0, r, e);
        check_output("abort_unchanged", r, exp_dummy);

        // Randomized mix over the initialised region on both instances.
        begin
            int inst;
            bit hold;
            logic [1:0] sz;
            inst = 0;
            for (int n = 0; n < 200; n++) begin
                if (!pending) inst = int'($urandom_range(0, 1));
                hold = (n != 199) && ($urandom_range(0, 3) == 0);
                sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                apply_stimulus(inst, 1'($urandom), 1'($urandom), sz,
                               ADDR_W'($urandom_range(0, 255)), $urandom, hold, r, e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
